// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling and 2-of-3 majority voting per bit.
// Received bytes land in a one-entry buffer drained through a valid/ready handshake.
module uart_rx_os16 #(
  parameter int OS_DIV = 54
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  input  logic       rx_ready,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int PW = (OS_DIV > 2) ? $clog2(OS_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic          sync1, rxs;
  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    os_cnt;
  logic [1:0]    samp;
  logic          bit_val;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          maj_now;
  logic          resolve;
  logic          load;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == PW'(OS_DIV - 1));

  // samp holds the os_cnt 7 and 8 samples; the live rxs is the third vote at os_cnt 9.
  assign maj_now = (samp[1] & samp[0]) | (samp[1] & rxs) | (samp[0] & rxs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    resolve   = 1'b0;
    case (state)
      IDLE: begin
        if (tick && !rxs) state_nxt = START;
      end
      START: begin
        if (tick && os_cnt == 4'd9 && maj_now) state_nxt = IDLE;
        else if (tick && os_cnt == 4'd15)      state_nxt = DATA;
      end
      DATA: begin
        if (tick && os_cnt == 4'd15 && bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP: begin
        if (tick && os_cnt == 4'd9) begin
          state_nxt = IDLE;
          resolve   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt  <= '0;
      samp    <= 2'b11;
      bit_val <= 1'b1;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (tick) begin
      if (state == IDLE && !rxs) begin
        os_cnt <= '0;
      end else begin
        os_cnt <= os_cnt + 1'b1;
      end
      if (os_cnt == 4'd7 || os_cnt == 4'd8) begin
        samp <= {samp[0], rxs};
      end
      if (os_cnt == 4'd9) begin
        bit_val <= maj_now;
      end
      if (state == START && os_cnt == 4'd15) begin
        bit_idx <= '0;
      end
      // LSB arrives first, so shift in from the top.
      if (state == DATA && os_cnt == 4'd15) begin
        shreg   <= {bit_val, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  assign load = resolve && maj_now && (!rx_valid || rx_ready);

  // A load on the accepting edge wins, keeping rx_valid high with the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= resolve && !maj_now;
      overrun   <= resolve && maj_now && rx_valid && !rx_ready;
      if (load) begin
        data_out <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

Oversampling UART receiver for the board-to-board serial link: it recovers 8N1 bytes from the line driven by the far board's transmitter using 16× oversampling with majority voting. It flags framing errors and holds each received byte in a one-entry buffer with a valid/ready handshake toward the consuming logic. It sits beside the existing transmitter in the UART top level and is the hardened receive path for the link.

## Interface
- OS_DIV, default 54, clk cycles per oversample tick (bit period = 16 × OS_DIV clk; 54 ≈ 115200 baud at 100 MHz); legal range ≥ 2.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- serial_in  input  1  asynchronous serial line; idle high.
- data_out  output  8  received byte, valid while rx_valid = 1.
- rx_valid  output  1  holding buffer full.
- rx_ready  input  1  consumer accepts; handshake completes on a clk edge where rx_valid & rx_ready.
- frame_err  output  1  1-cycle pulse: stop bit sampled low, byte discarded.
- overrun  output  1  1-cycle pulse: byte completed while buffer full and not being drained, new byte dropped.
- rx_busy  output  1  high in any state other than IDLE.

## Operation
- Input synchroniser: 2 flops, reset to 1; all decisions use the second flop (`rxs`).
- Tick prescaler: free-running counter 0..OS_DIV−1, `tick` asserted for one clk when count = OS_DIV−1; counts from reset regardless of state.
- Oversample counter `os_cnt` (4 bits) advances only on `tick`, wraps 15→0.
- Majority vote: samples of `rxs` taken on ticks where os_cnt = 7, 8 and 9; bit value = at least 2 of 3 samples are 1.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: on `tick` with rxs = 0 → START, os_cnt ← 0.
  - START: on `tick` at os_cnt = 9: majority 1 (glitch) → IDLE; majority 0 → continue. At os_cnt = 15 → DATA, bit_idx ← 0.
  - DATA: on `tick` at os_cnt = 15, shift the majority bit in LSB-first. After bit_idx = 7 → STOP, else bit_idx + 1.
  - STOP: on `tick` at os_cnt = 9, resolve the frame and → IDLE. This is mid-stop-bit, so a back-to-back start bit is still caught.
- Frame resolution in STOP:
  - Majority 1, buffer empty or draining this cycle: data_out ← shift register, rx_valid ← 1.
  - Majority 1, buffer full and rx_ready = 0: data_out unchanged, overrun pulse.
  - Majority 0: frame_err pulse, buffer untouched.
- Handshake: rx_valid clears on the accepting edge unless a new byte loads on that same edge; a load wins and rx_valid stays 1. data_out is stable while rx_valid = 1 and is not accepted.

## Timing
- Reset values: data_out = 0x00, rx_valid = 0, frame_err = 0, overrun = 0, rx_busy = 0; FSM IDLE, prescaler 0, synchroniser 1s.
- Reset asserted mid-frame aborts the frame immediately. No byte, no error pulse.
- Start detection uncertainty: 2 clk (synchroniser) plus up to 1 tick. The sample point drifts no more than 1/16 bit from centre.
- Byte latency: rx_valid rises on the clk edge after the tick at stop-bit os_cnt = 9, about 9.5 bit periods after the start edge.
- frame_err and overrun are exactly one clk wide. Neither is asserted in the same cycle as the other.
- rx_busy is high from the edge entering START until the edge returning to IDLE.

## Test plan
All scenarios use OS_DIV = 4, so bit period = 64 clk.
- Send 0xA5 (8N1), rx_ready = 0 → rx_valid = 1 with data_out = 0xA5 about 608 clk after the start edge; held until rx_ready; then rx_valid = 0 the next cycle.
- Low glitch on serial_in of 16 clk (4 ticks) from idle → FSM returns to IDLE at os_cnt = 9 of START; rx_valid, frame_err and overrun stay 0.
- Send 0x3C with stop bit driven 0 → single-cycle frame_err; rx_valid stays 0; the next valid byte 0x5A is received normally.
- Send 0x11 then 0x22 back-to-back with rx_ready = 0 → data_out = 0x11 retained, one overrun pulse at the second stop bit.
- Back-to-back 0x33, 0x44 with rx_ready asserted exactly on the edge where 0x44 loads → rx_valid stays 1, data_out = 0x44, no overrun.
- Assert rst_n = 0 during DATA bit 3, release, then send 0x7E → all outputs return to 0 during reset and only 0x7E is delivered.
